dfi_loopback_responder: RTL

DFI_LOOPBACK_RESPONDER -- requirements
Module: dfi_loopback_responder

---
 rtl/dfi_loopback_if.sv | 30 +++
 rtl/dfi_loopback_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dfi_loopback_if.sv
// DFI write/read data-path bundle between a controller (master) and a PHY-side
// responder (slave); phase n occupies bits [n*DATA_W +: DATA_W].
interface dfi_loopback_if #(
    parameter int unsigned DATA_W = 32
);
    logic [3:0]              dfi_wrdata_en;
    logic [4*DATA_W-1:0]     dfi_wrdata;
    logic [4*DATA_W/8-1:0]   dfi_wrdata_mask;
    logic [3:0]              dfi_rddata_en;
    logic [4*DATA_W-1:0]     dfi_rddata;
    logic [3:0]              dfi_rddata_valid;

    modport master (
        output dfi_wrdata_en,
        output dfi_wrdata,
        output dfi_wrdata_mask,
        output dfi_rddata_en,
        input  dfi_rddata,
        input  dfi_rddata_valid
    );

    modport slave (
        input  dfi_wrdata_en,
        input  dfi_wrdata,
        input  dfi_wrdata_mask,
        input  dfi_rddata_en,
        output dfi_rddata,
        output dfi_rddata_valid
    );
endinterface

// File: rtl/dfi_loopback_responder.sv
// DFI loopback responder: latency-delayed write enables push masked write data into a
// circular store, latency-delayed read enables pop it back one registered cycle later.
module dfi_loopback_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_LAT = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wr_lat_cfg,
    input  logic [7:0]               rd_lat_cfg,
    dfi_loopback_if.slave            dfi,
    input  logic                     clear_err,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic                     underflow,
    output logic [15:0]              wr_count,
    output logic [15:0]              rd_count
);
    localparam int unsigned EW  = 4 * DATA_W;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned OW  = AW + 1;
    localparam int unsigned LW  = $clog2(MAX_LAT + 1);
    localparam int          NL  = int'(MAX_LAT);
    localparam int          BPP = int'(DATA_W / 8);

    // Stage i holds the enable vector presented i+1 cycles ago.
    logic [3:0]    wen_pipe_q [MAX_LAT];
    logic [3:0]    ren_pipe_q [MAX_LAT];
    logic [LW-1:0] wr_lat;
    logic [LW-1:0] rd_lat;
    logic [3:0]    wen_d;
    logic [3:0]    ren_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occupancy_q, occupancy_d;
    logic          overflow_q, underflow_q;
    logic [15:0]   wr_count_q, rd_count_q;
    logic [EW-1:0] rddata_q, rddata_d;
    logic [3:0]    rddata_valid_q;
    logic [EW-1:0] push_entry;

    logic full, empty, push, pop, push_ok, pop_ok;

    assign wr_lat = (wr_lat_cfg > 8'(MAX_LAT)) ? LW'(MAX_LAT) : LW'(wr_lat_cfg);
    assign rd_lat = (rd_lat_cfg > 8'(MAX_LAT)) ? LW'(MAX_LAT) : LW'(rd_lat_cfg);

    assign wen_d = (wr_lat == '0) ? dfi.dfi_wrdata_en : wen_pipe_q[wr_lat - LW'(1)];
    assign ren_d = (rd_lat == '0) ? dfi.dfi_rddata_en : ren_pipe_q[rd_lat - LW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NL; i++) begin
                wen_pipe_q[i] <= '0;
                ren_pipe_q[i] <= '0;
            end
        end else begin
            wen_pipe_q[0] <= dfi.dfi_wrdata_en;
            ren_pipe_q[0] <= dfi.dfi_rddata_en;
            for (int i = 1; i < NL; i++) begin
                wen_pipe_q[i] <= wen_pipe_q[i-1];
                ren_pipe_q[i] <= ren_pipe_q[i-1];
            end
        end
    end

    assign full    = (occupancy_q == OW'(DEPTH));
    assign empty   = (occupancy_q == '0);
    assign push    = |wen_d;
    assign pop     = |ren_d;
    // A pop in the same cycle frees the slot, so a full store still accepts the push.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        push_entry = '0;
        for (int n = 0; n < 4; n++) begin
            for (int b = 0; b < BPP; b++) begin
                if (wen_d[n] && !dfi.dfi_wrdata_mask[n*BPP + b]) begin
                    push_entry[n*int'(DATA_W) + b*8 +: 8] =
                        dfi.dfi_wrdata[n*int'(DATA_W) + b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rddata_d = '0;
        if (pop_ok) begin
            for (int n = 0; n < 4; n++) begin
                if (ren_d[n]) begin
                    rddata_d[n*int'(DATA_W) +: DATA_W] = mem_q[rd_ptr_q][n*int'(DATA_W) +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        occupancy_d = occupancy_q;
        unique case ({push_ok, pop_ok})
            2'b10:   occupancy_d = occupancy_q + OW'(1);
            2'b01:   occupancy_d = occupancy_q - OW'(1);
            default: occupancy_d = occupancy_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occupancy_q    <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            wr_count_q     <= '0;
            rd_count_q     <= '0;
            rddata_q       <= '0;
            rddata_valid_q <= '0;
        end else begin
            occupancy_q    <= occupancy_d;
            rddata_q       <= rddata_d;
            rddata_valid_q <= ren_d;
            if (push_ok) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            // A new error event outranks a simultaneous clear.
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (clear_err) begin
                overflow_q <= 1'b0;
            end
            if (pop && empty) begin
                underflow_q <= 1'b1;
            end else if (clear_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign dfi.dfi_rddata       = rddata_q;
    assign dfi.dfi_rddata_valid = rddata_valid_q;
    assign occupancy            = occupancy_q;
    assign overflow             = overflow_q;
    assign underflow            = underflow_q;
    assign wr_count             = wr_count_q;
    assign rd_count             = rd_count_q;
endmodule
